// File: rtl/field_display_pipe.sv
// Three-stage playfield pixel generator: address split, cell decode, colour select.
// Includes cell outlines and a frame-counted row-clear flash sequencer.
module field_display_pipe #(
  parameter int unsigned COLS          = 10,
  parameter int unsigned ROWS          = 10,
  parameter int unsigned CELL          = 48,
  parameter int unsigned H_RES         = 640,
  parameter int unsigned FLASH_PERIOD  = 4,
  parameter int unsigned FLASH_TOGGLES = 6,
  parameter logic [23:0] PAL1          = 24'h00aa00,
  parameter logic [23:0] PAL2          = 24'h0000cc,
  parameter logic [23:0] PAL3          = 24'hcc8800,
  parameter logic [23:0] BORDER_COLOR  = 24'h202020,
  parameter logic [23:0] FLASH_COLOR   = 24'hffffff,
  parameter logic [23:0] BG_COLOR      = 24'h000000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [18:0]              ADDR,
  input  logic [2*COLS*ROWS-1:0]   field,
  input  logic [23:0]              score_rgb,
  input  logic                     frame_start,
  input  logic                     clear_start,
  input  logic [ROWS-1:0]          clear_rows,
  output logic [23:0]              bgr_data,
  output logic                     busy,
  output logic                     clear_done
);

  localparam int unsigned AW  = 19;
  localparam int unsigned CW  = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned RW  = $clog2((2**AW) / H_RES + 1);
  localparam int unsigned PW  = (CELL > 1) ? $clog2(CELL) : 1;
  localparam int unsigned IW  = 4;
  localparam int unsigned FCW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
  localparam int unsigned TCW = $clog2(FLASH_TOGGLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} state_e;

  // S1
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic [23:0]     sc1_q;
  // S2
  logic [IW-1:0]   x_q, y_q;
  logic [PW-1:0]   px_q, py_q;
  logic            in_x_q, in_y_q;
  logic [23:0]     sc2_q;
  // S3
  logic [23:0]     bgr_q, bgr_d;

  // flash sequencer
  state_e          state_q;
  logic [FCW-1:0]  fc_q;
  logic [TCW-1:0]  tc_q;
  logic [ROWS-1:0] mask_q;
  logic            busy_q, done_q;

  int              idx_c;
  logic [1:0]      code_c;
  logic            outline_c, flash_row_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      sc1_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      px_q   <= '0;
      py_q   <= '0;
      in_x_q <= 1'b0;
      in_y_q <= 1'b0;
      sc2_q  <= '0;
      bgr_q  <= BG_COLOR;
    end else begin
      col_q  <= CW'(32'(ADDR) % H_RES);
      row_q  <= RW'(32'(ADDR) / H_RES);
      sc1_q  <= score_rgb;
      x_q    <= IW'(32'(col_q) / CELL);
      y_q    <= IW'(32'(row_q) / CELL);
      px_q   <= PW'(32'(col_q) % CELL);
      py_q   <= PW'(32'(row_q) % CELL);
      in_x_q <= (32'(col_q) / CELL) < COLS;
      in_y_q <= (32'(row_q) / CELL) < ROWS;
      sc2_q  <= sc1_q;
      bgr_q  <= bgr_d;
    end
  end

  // Cell code select and colour priority; x/y are only trusted once in_x/in_y hold.
  always_comb begin
    idx_c  = int'(y_q) * int'(COLS) + int'(x_q);
    code_c = 2'b00;
    for (int k = 0; k < int'(COLS * ROWS); k++) begin
      if (k == idx_c) code_c = field[2*k +: 2];
    end
    outline_c   = (px_q == '0) || (px_q == PW'(CELL - 1)) ||
                  (py_q == '0) || (py_q == PW'(CELL - 1));
    flash_row_c = busy_q && (|(mask_q & (ROWS'(1) << y_q)));
    bgr_d = BG_COLOR;
    if (!in_x_q)                         bgr_d = sc2_q;
    else if (!in_y_q)                    bgr_d = BG_COLOR;
    else if (flash_row_c)                bgr_d = (state_q == ST_ON) ? FLASH_COLOR : BG_COLOR;
    else if (code_c != 2'b00 && outline_c) bgr_d = BORDER_COLOR;
    else begin
      case (code_c)
        2'd1:    bgr_d = PAL1;
        2'd2:    bgr_d = PAL2;
        2'd3:    bgr_d = PAL3;
        default: bgr_d = BG_COLOR;
      endcase
    end
  end

  // Flash sequencer; a frame_start coinciding with the start request is not counted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fc_q    <= '0;
      tc_q    <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (clear_start) begin
            if (clear_rows == '0) begin
              done_q <= 1'b1;
            end else begin
              mask_q  <= clear_rows;
              fc_q    <= '0;
              tc_q    <= '0;
              busy_q  <= 1'b1;
              state_q <= ST_ON;
            end
          end
        end
        ST_ON, ST_OFF: begin
          if (frame_start) begin
            if (fc_q == FCW'(FLASH_PERIOD - 1)) begin
              fc_q <= '0;
              if (tc_q == TCW'(FLASH_TOGGLES - 1)) begin
                tc_q    <= '0;
                mask_q  <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= ST_IDLE;
              end else begin
                tc_q    <= tc_q + TCW'(1);
                state_q <= (state_q == ST_ON) ? ST_OFF : ST_ON;
              end
            end else begin
              fc_q <= fc_q + FCW'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bgr_data   = bgr_q;
  assign busy       = busy_q;
  assign clear_done = done_q;

endmodule

// File: tb/tb_field_display_pipe.sv
// Directed bench for field_display_pipe: pixel colours, streaming, flash sequencing, reset abort.
module tb_field_display_pipe;

  logic         clock;
  logic         reset;
  logic [18:0]  addr;
  logic [199:0] field;
  logic [23:0]  score_rgb;
  logic         frame_start;
  logic         clear_start;
  logic [9:0]   clear_rows;
  logic [23:0]  bgr_data;
  logic         busy;
  logic         clear_done;

  int errors = 0;
  int checks = 0;
  logic [23:0] expq[$];

  localparam int P0 = 24*640 + 72;   // row 0, cell x=1 (kept empty)
  localparam int P1 = 72*640 + 24;   // row 1, cell x=0

  field_display_pipe dut (
    .clock(clock), .reset(reset), .ADDR(addr), .field(field),
    .score_rgb(score_rgb), .frame_start(frame_start), .clear_start(clear_start),
    .clear_rows(clear_rows), .bgr_data(bgr_data), .busy(busy), .clear_done(clear_done)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic probe(input int a, input logic [23:0] s, input logic [23:0] exp, input string tag);
    addr      = 19'(a);
    score_rgb = s;
    step();
    step();
    step();
    check(tag, bgr_data, exp);
  endtask

  function automatic logic [23:0] model(input int a, input logic [23:0] s);
    int col, row, x, y, px, py;
    logic [1:0] code;
    col = a % 640;  row = a / 640;
    x = col / 48;   y = row / 48;
    px = col % 48;  py = row % 48;
    if (x >= 10) return s;
    if (y >= 10) return 24'h000000;
    code = field[2*(y*10+x) +: 2];
    if (code == 2'd0) return 24'h000000;
    if (px == 0 || px == 47 || py == 0 || py == 47) return 24'h202020;
    case (code)
      2'd1:    return 24'h00aa00;
      2'd2:    return 24'h0000cc;
      default: return 24'hcc8800;
    endcase
  endfunction

  task automatic stream(input int base);
    expq.delete();
    for (int i = 0; i < 642; i++) begin
      if (i < 640) begin
        addr      = 19'(base + i);
        score_rgb = 24'(i*3 + 7);
        expq.push_back(model(base + i, score_rgb));
      end
      step();
      if (i >= 2) check("stream", bgr_data, expq.pop_front());
    end
  endtask

  initial begin
    clock = 1'b0; reset = 1'b1; addr = '0; field = '0; score_rgb = '0;
    frame_start = 1'b0; clear_start = 1'b0; clear_rows = '0;
    #2;
    check("reset_bgr",  bgr_data, 24'h000000);
    check("reset_busy", 24'(busy), 24'h0);
    check("reset_done", 24'(clear_done), 24'h0);
    step();
    reset = 1'b0;
    step();

    // single-pixel colours
    field[1:0] = 2'b01;
    probe(0, 24'h0, 24'h202020, "outline");
    probe(24*640 + 24, 24'h0, 24'h00aa00, "pal1");
    field[1:0] = 2'b11;
    probe(24*640 + 24, 24'h0, 24'hcc8800, "pal3");
    probe(100*640 + 500, 24'h123456, 24'h123456, "score_pass");
    probe(490*640 + 100, 24'h123456, 24'h000000, "below_field");

    // back-to-back streaming across two lines
    for (int k = 0; k < 100; k++) field[2*k +: 2] = 2'((k*3 + 1) % 4);
    stream(0);
    stream(24*640);

    // flash sequence, started together with a frame_start that must not count
    field = '0;
    field[2*10 +: 2] = 2'b10;
    clear_rows = 10'b0000000001; clear_start = 1'b1; frame_start = 1'b1;
    step();
    clear_start = 1'b0; frame_start = 1'b0; clear_rows = '0;
    check("busy_start", 24'(busy), 24'h1);
    for (int k = 0; k < 24; k++) begin
      probe(P0, 24'h0, (((k/4) % 2) == 0) ? 24'hffffff : 24'h000000, "flash_row0");
      if (k == 5) begin
        clear_rows = 10'b0000000010; clear_start = 1'b1;
        step();
        clear_start = 1'b0; clear_rows = '0;
        probe(P1, 24'h0, 24'h0000cc, "ignored_clear");
      end
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      check("seq_done", 24'(clear_done), (k == 23) ? 24'h1 : 24'h0);
      check("seq_busy", 24'(busy), (k == 23) ? 24'h0 : 24'h1);
      step();
    end
    check("done_single", 24'(clear_done), 24'h0);
    probe(P0, 24'h0, 24'h000000, "after_clear");

    // empty mask completes at once
    clear_rows = '0; clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    check("zero_done", 24'(clear_done), 24'h1);
    check("zero_busy", 24'(busy), 24'h0);
    step();
    check("zero_done_end", 24'(clear_done), 24'h0);
    check("zero_busy_end", 24'(busy), 24'h0);

    // reset abort after 10 counted frames
    clear_rows = 10'b0000000001; clear_start = 1'b1;
    step();
    clear_start = 1'b0; clear_rows = '0;
    for (int k = 0; k < 10; k++) begin
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      step();
    end
    probe(P0, 24'h0, 24'hffffff, "pre_reset");
    #3;
    reset = 1'b1;
    #1;
    check("async_bgr",  bgr_data, 24'h000000);
    check("async_busy", 24'(busy), 24'h0);
    check("async_done", 24'(clear_done), 24'h0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      check("abort_done", 24'(clear_done), 24'h0);
      check("abort_busy", 24'(busy), 24'h0);
      step();
    end
    probe(P0, 24'h0, 24'h000000, "abort_row0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
